// File: rtl/pdl_challenge_sequencer.sv
// Host front end for the PDL PUF path: collects a byte-serial challenge frame,
// runs the mapping stage N times, and returns status, majority and stability bytes.
module pdl_challenge_sequencer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 map_trigger,
  output logic [IN_WIDTH-1:0]  map_challenge,
  output logic [15:0]          map_opA,
  output logic [15:0]          map_opB,
  input  logic                 map_done,
  input  logic [OUT_WIDTH-1:0] map_response,
  output logic                 busy
);

  localparam int IN_BYTES    = IN_WIDTH / 8;
  localparam int FRAME_BYTES = IN_BYTES + 5;
  localparam int OUT_BYTES   = OUT_WIDTH / 8;
  localparam int SEND_BYTES  = 1 + 2 * OUT_BYTES;
  localparam int SH_W        = IN_WIDTH + 32;
  localparam int OB_W        = 8 * SEND_BYTES;
  localparam int FC_W        = $clog2(FRAME_BYTES);
  localparam int SC_W        = $clog2(SEND_BYTES);
  localparam int TO_W        = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_RECV = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  logic [2:0]           state;
  logic [FC_W-1:0]      in_cnt;
  logic [SH_W-1:0]      shadow;
  logic [SH_W+7:0]      frame;
  logic [8:0]           n_runs;
  logic [8:0]           runs_left;
  logic [TO_W-1:0]      to_cnt;
  logic                 to_flag;
  logic [8:0]           ones [OUT_WIDTH];
  logic [OB_W-1:0]      out_buf;
  logic [SC_W-1:0]      out_cnt;
  logic [OUT_WIDTH-1:0] majority;
  logic [OUT_WIDTH-1:0] stable;
  logic                 in_accept;
  logic                 frame_last;
  logic                 out_accept;
  logic                 wait_done;

  assign in_ready    = (state == S_RECV) && !reset;
  assign out_valid   = (state == S_SEND);
  assign map_trigger = (state == S_TRIG);
  assign busy        = (state != S_RECV);
  assign out_data    = out_buf[OB_W-1 -: 8];

  assign in_accept  = in_ready && in_valid;
  assign frame_last = in_accept && (in_cnt == FC_W'(FRAME_BYTES - 1));
  assign out_accept = out_valid && out_ready;
  assign wait_done  = (state == S_WAIT) && map_done;

  // Complete frame as it stands once the current byte is appended.
  assign frame = {shadow, in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RECV;
      in_cnt        <= '0;
      shadow        <= '0;
      map_challenge <= '0;
      map_opA       <= '0;
      map_opB       <= '0;
      n_runs        <= '0;
      runs_left     <= '0;
      to_cnt        <= '0;
      to_flag       <= 1'b0;
      out_buf       <= '0;
      out_cnt       <= '0;
    end else begin
      case (state)
        S_RECV: begin
          if (in_accept) begin
            shadow <= frame[SH_W-1:0];
            if (frame_last) begin
              in_cnt        <= '0;
              map_challenge <= frame[SH_W+7 -: IN_WIDTH];
              map_opA       <= frame[39:24];
              map_opB       <= frame[23:8];
              n_runs        <= {1'b0, in_data} + 9'd1;
              runs_left     <= {1'b0, in_data} + 9'd1;
              to_flag       <= 1'b0;
              state         <= S_TRIG;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        S_TRIG: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          // A completion in the very cycle the limit is reached still counts.
          if (map_done) begin
            runs_left <= runs_left - 1'b1;
            state     <= (runs_left == 9'd1) ? S_EVAL : S_TRIG;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            to_flag <= 1'b1;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          out_buf <= {7'b0, to_flag, majority, stable};
          out_cnt <= '0;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (out_accept) begin
            out_buf <= {out_buf[OB_W-9:0], 8'h00};
            if (out_cnt == SC_W'(SEND_BYTES - 1)) begin
              state <= S_RECV;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= S_RECV;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_last) begin
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
        ones[i] <= '0;
      end
    end else if (wait_done) begin
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
        ones[i] <= ones[i] + {8'b0, map_response[i]};
      end
    end
  end

  // Strict majority: 2*ones > N, so an exact tie resolves to 0.
  always_comb begin
    majority = '0;
    stable   = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      majority[i] = ({ones[i], 1'b0} > {1'b0, n_runs}) && !to_flag;
      stable[i]   = ((ones[i] == 9'd0) || (ones[i] == n_runs)) && !to_flag;
    end
  end

endmodule

// File: tb/tb_pdl_challenge_sequencer.sv
// Scoreboard bench for pdl_challenge_sequencer with a behavioural mapping model
// and a frame-level reference computed from per-bit vote counts.
module tb_pdl_challenge_sequencer;

  localparam int IN_WIDTH  = 128;
  localparam int OUT_WIDTH = 16;
  localparam int TIMEOUT   = 64;
  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           in_data = 8'h00;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 map_trigger;
  logic [IN_WIDTH-1:0]  map_challenge;
  logic [15:0]          map_opA;
  logic [15:0]          map_opB;
  logic                 model_done = 1'b0;
  logic                 late_done = 1'b0;
  logic                 map_done;
  logic [OUT_WIDTH-1:0] map_response = '0;
  logic                 busy;

  assign map_done = model_done | late_done;

  pdl_challenge_sequencer #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .map_trigger  (map_trigger),
    .map_challenge(map_challenge),
    .map_opA      (map_opA),
    .map_opB      (map_opB),
    .map_done     (map_done),
    .map_response (map_response),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0]           exp_q[$];
  logic [OUT_WIDTH-1:0] frame_resps[$];
  logic [OUT_WIDTH-1:0] resp_tab[$];
  int  lat = 1;
  bit  hang = 1'b0;
  bit  chain = 1'b0;
  int  trig_count = 0;
  int  last_trig = -1;
  int  last_done = -1;
  int  rdy_mode = 0;

  // Mapping model: answers each trigger after `lat` cycles with the next queued response.
  initial begin
    forever begin
      if (!reset && map_trigger) begin
        trig_count++;
        if (chain) check("trigger one cycle after done", cyc - last_done, 1);
        chain = 1'b0;
        last_trig = cyc;
        if (!hang && resp_tab.size() > 0) begin
          logic [OUT_WIDTH-1:0] r;
          r = resp_tab.pop_front();
          repeat (lat) @(negedge clk);
          model_done   = 1'b1;
          map_response = r;
          last_done    = cyc;
          chain        = (resp_tab.size() > 0);
          @(negedge clk);
          model_done   = 1'b0;
          map_response = OUT_WIDTH'($urandom);
        end else begin
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Output acceptance policy.
  initial begin
    int vcnt;
    vcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      vcnt = out_valid ? vcnt + 1 : 0;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !(vcnt >= 3 && vcnt <= 5);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output byte.
  initial begin
    logic [7:0] prev_d;
    bit         prev_stall;
    prev_d = 8'h00;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("out_valid held while stalled", out_valid, 1);
          check("out_data stable while stalled", out_data, prev_d);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected output byte: got %0h, expected none", out_data);
          end else begin
            check("output byte", out_data, exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
      end
    end
  end

  function automatic void push_expected(input int n, input bit to);
    logic [OUT_WIDTH-1:0] maj;
    logic [OUT_WIDTH-1:0] stb;
    int cnt;
    maj = '0;
    stb = '0;
    for (int b = 0; b < OUT_WIDTH; b++) begin
      cnt = 0;
      foreach (frame_resps[k]) cnt += int'(frame_resps[k][b]);
      maj[b] = (2 * cnt > n);
      stb[b] = (cnt == 0) || (cnt == n);
    end
    if (to) begin
      maj = '0;
      stb = '0;
    end
    exp_q.push_back(to ? 8'h01 : 8'h00);
    for (int k = OUT_BYTES - 1; k >= 0; k--) exp_q.push_back(maj[8*k +: 8]);
    for (int k = OUT_BYTES - 1; k >= 0; k--) exp_q.push_back(stb[8*k +: 8]);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (w = 0; w < 500; w++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("in_ready within bound", (w < 500), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [IN_WIDTH-1:0] chal, input logic [15:0] opa,
                            input logic [15:0] opb, input logic [7:0] r, input int gap_mode);
    logic [7:0] tail [5];
    tail[0] = opa[15:8];
    tail[1] = opa[7:0];
    tail[2] = opb[15:8];
    tail[3] = opb[7:0];
    tail[4] = r;
    for (int i = 0; i < IN_BYTES; i++)
      send_byte(chal[IN_WIDTH-1-8*i -: 8], gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1));
    for (int i = 0; i < 5; i++)
      send_byte(tail[i], gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1));
  endtask

  task automatic run_frame(input logic [IN_WIDTH-1:0] chal, input logic [15:0] opa,
                           input logic [15:0] opb, input logic [7:0] r, input bit hng,
                           input int lt, input int gap_mode, input bit exp_to);
    int n, t0, w, bound, exp_cyc;
    n = int'(r) + 1;
    push_expected(n, exp_to);
    resp_tab = frame_resps;
    hang = hng;
    lat = lt;
    t0 = trig_count;
    send_frame(chal, opa, opb, r, gap_mode);
    @(negedge clk);
    check("busy after last byte", busy, 1);
    check("map_trigger after last byte", map_trigger, 1);
    check("map_challenge", map_challenge, chal);
    check("map_opA", map_opA, opa);
    check("map_opB", map_opB, opb);
    bound = n * (lt + 4) + TIMEOUT + 40;
    for (w = 0; w < bound; w++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("out_valid within bound", out_valid, 1);
    exp_cyc = exp_to ? last_trig + TIMEOUT + 3 : last_done + 2;
    check("first out_valid cycle", cyc, exp_cyc);
    check("in_ready low while busy", in_ready, 0);
    check("trigger count", trig_count - t0, exp_to ? 1 : n);
    for (w = 0; w < 200; w++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("busy clears", busy, 0);
    check("in_ready after last output", in_ready, 1);
    check("scoreboard drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    resp_tab.delete();
    hang = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    resp_tab.delete();
    @(negedge clk);
    check("in_ready low during reset", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset map_trigger", map_trigger, 0);
    check("reset busy", busy, 0);
    check("reset map_challenge", map_challenge, 0);
    check("reset map_opA", map_opA, 0);
    check("reset map_opB", map_opB, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chain = 1'b0;
    hang  = 1'b0;
    @(negedge clk);
    check("in_ready after reset release", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_WIDTH-1:0] rand_chal();
    logic [IN_WIDTH-1:0] c;
    for (int i = 0; i < IN_WIDTH / 32; i++) c[32*i +: 32] = $urandom;
    return c;
  endfunction

  task automatic random_frame(input int gap_mode);
    logic [7:0] r;
    r = 8'($urandom_range(0, 7));
    frame_resps.delete();
    for (int i = 0; i <= int'(r); i++) frame_resps.push_back(OUT_WIDTH'($urandom) | OUT_WIDTH'($urandom));
    run_frame(rand_chal(), 16'($urandom), 16'($urandom), r, 1'b0, $urandom_range(1, 20), gap_mode, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_WIDTH-1:0] seq_chal;
    bit                  bit0 [256];
    do_reset();

    // Single run with the ascending challenge.
    for (int i = 0; i < IN_BYTES; i++) seq_chal[IN_WIDTH-1-8*i -: 8] = 8'(i);
    frame_resps = '{16'hA5C3};
    run_frame(seq_chal, 16'h1234, 16'h0F0F, 8'd0, 1'b0, 17, 0, 1'b0);

    // Three-run vote.
    frame_resps = '{16'hFFFF, 16'h0F0F, 16'h00FF};
    run_frame(rand_chal(), 16'hBEEF, 16'h0102, 8'd2, 1'b0, 3, 0, 1'b0);

    // 256 runs: bit 0 set on exactly half, bit 15 always.
    for (int i = 0; i < 256; i++) bit0[i] = (i < 128);
    for (int i = 255; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(0, i);
      t = bit0[i];
      bit0[i] = bit0[j];
      bit0[j] = t;
    end
    frame_resps.delete();
    for (int i = 0; i < 256; i++) frame_resps.push_back({1'b1, 14'h0, bit0[i]});
    run_frame(rand_chal(), 16'h5555, 16'hAAAA, 8'd255, 1'b0, 1, 0, 1'b0);

    // Mapping never answers; remaining runs are abandoned.
    frame_resps.delete();
    run_frame(rand_chal(), 16'h0001, 16'h0002, 8'd3, 1'b1, 1, 0, 1'b1);

    // Completion exactly at the limit still counts.
    frame_resps = '{16'h1357};
    run_frame(rand_chal(), 16'h0003, 16'h0004, 8'd0, 1'b0, TIMEOUT + 1, 0, 1'b0);

    // One cycle too late: timeout, and the late pulse lands in EVAL.
    frame_resps = '{16'hFFFF};
    run_frame(rand_chal(), 16'h0005, 16'h0006, 8'd0, 1'b0, TIMEOUT + 2, 0, 1'b1);

    // Stray completion pulse while idle.
    late_done = 1'b1;
    map_response = '1;
    @(posedge clk);
    #1;
    late_done = 1'b0;

    // Input gaps and a 3-cycle output stall.
    rdy_mode = 2;
    frame_resps = '{16'h8001, 16'h8003};
    run_frame(rand_chal(), 16'hC0DE, 16'hF00D, 8'd1, 1'b0, 5, 1, 1'b0);

    rdy_mode = 1;
    for (int f = 0; f < 12; f++) random_frame(2);
    rdy_mode = 0;

    // Reset mid-frame.
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
    do_reset();
    random_frame(0);

    // Reset while waiting on mapping.
    frame_resps.delete();
    hang = 1'b1;
    send_frame(rand_chal(), 16'h7777, 16'h8888, 8'd4, 0);
    repeat (10) @(negedge clk);
    check("busy during wait", busy, 1);
    @(posedge clk);
    #1;
    do_reset();
    random_frame(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
